// File: rtl/unit_arr_batch_collector.sv
// unit_arr_batch_collector: buffers N unit vectors and presents them as one parallel batch
package unit_arr_batch_collector_pkg;
  typedef logic [15:0] unit_t;
endpackage

module unit_arr_batch_collector
  import unit_arr_batch_collector_pkg::*;
#(
  parameter int N   = 16,
  parameter int LEN = 32,
  parameter int CW  = $clog2(N+1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  unit_t [LEN-1:0]             in_vec,
  input  logic                        in_valid,
  output logic                        in_ready,
  output unit_t [N-1:0][LEN-1:0]      batch_out,
  output logic                        batch_valid,
  input  logic                        batch_ready,
  output logic [CW-1:0]               fill_level
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic {FILL, FULL} state_t;
  state_t                   state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     batch_valid_q, batch_valid_d;
  unit_t [N-1:0][LEN-1:0]   slots_q, slots_d;
  logic                     accept, release_b;
  logic [IW-1:0]            idx;
  assign idx         = count_q[IW-1:0];
  assign batch_out   = slots_q;
  assign batch_valid = batch_valid_q;
  assign fill_level  = count_q;
  // next-state: clear beats accept and release; FULL blocks accepts so count never wraps
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    batch_valid_d = batch_valid_q;
    slots_d       = slots_q;
    in_ready      = (state_q == FILL) && !clear;
    accept        = in_valid && in_ready;
    release_b     = batch_valid_q && batch_ready && !clear;
    if (clear) begin
      state_d       = FILL;
      count_d       = '0;
      batch_valid_d = 1'b0;
    end else if (accept) begin
      slots_d[idx]  = in_vec;
      count_d       = count_q + CW'(1);
      state_d       = (count_q == CW'(N-1)) ? FULL : FILL;
      batch_valid_d = (count_q == CW'(N-1));
    end else if (release_b) begin
      state_d       = FILL;
      count_d       = '0;
      batch_valid_d = 1'b0;
    end
  end
  // state and batch storage; reset zeroes the slots as well
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FILL;
      count_q       <= '0;
      batch_valid_q <= 1'b0;
      slots_q       <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      batch_valid_q <= batch_valid_d;
      slots_q       <= slots_d;
    end
  end
endmodule

// File: tb/tb_unit_arr_batch_collector.sv
// tb_unit_arr_batch_collector: directed scenario bench for the batch collector
module tb_unit_arr_batch_collector;
  import unit_arr_batch_collector_pkg::*;
  localparam int N = 4;
  localparam int LEN = 2;
  localparam int CW = $clog2(N+1);
  logic clk = 0;
  logic rst_n = 0;
  logic clear = 0;
  unit_t [LEN-1:0] in_vec = '0;
  logic in_valid = 0;
  logic in_ready;
  unit_t [N-1:0][LEN-1:0] batch_out;
  logic batch_valid;
  logic batch_ready = 0;
  logic [CW-1:0] fill_level;
  int vec_cnt = 0;
  int err_cnt = 0;
  unit_t [N-1:0][LEN-1:0] exp_b;
  unit_t [N-1:0][LEN-1:0] snap;

  unit_arr_batch_collector #(.N(N), .LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready), .batch_out(batch_out), .batch_valid(batch_valid),
    .batch_ready(batch_ready), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int base);
    in_vec[0] = unit_t'(base);
    in_vec[1] = unit_t'(base + 1);
  endtask

  task automatic test_reset;
    rst_n = 0;
    #12;
    rst_n = 1;
    #1;
    vec_cnt++; if (batch_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_bv got %0b exp 0", batch_valid); end
    vec_cnt++; if (fill_level !== 3'd0) begin err_cnt++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    vec_cnt++; if (batch_out !== '0) begin err_cnt++; $display("FAIL reset_slots got %0h exp 0", batch_out); end
    tick;
  endtask

  task automatic test_stream;
    in_valid = 1;
    for (int k = 0; k < N; k++) begin
      set_vec(k*LEN);
      #1;
      vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL stream_ready k=%0d got %0b exp 1", k, in_ready); end
      vec_cnt++; if (batch_valid !== 1'b0) begin err_cnt++; $display("FAIL stream_bv_early k=%0d got %0b exp 0", k, batch_valid); end
      tick;
    end
    in_valid = 0;
    for (int k = 0; k < N; k++) begin
      exp_b[k][0] = unit_t'(k*LEN);
      exp_b[k][1] = unit_t'(k*LEN + 1);
    end
    vec_cnt++; if (batch_valid !== 1'b1) begin err_cnt++; $display("FAIL stream_bv got %0b exp 1", batch_valid); end
    vec_cnt++; if (fill_level !== 3'd4) begin err_cnt++; $display("FAIL stream_fill got %0d exp 4", fill_level); end
    vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL stream_in_ready got %0b exp 0", in_ready); end
    vec_cnt++; if (batch_out[2][1] !== 16'd5 || batch_out[2][0] !== 16'd4) begin err_cnt++; $display("FAIL stream_slot2 got %0d,%0d exp 5,4", batch_out[2][1], batch_out[2][0]); end
    vec_cnt++; if (batch_out !== exp_b) begin err_cnt++; $display("FAIL stream_batch got %0h exp %0h", batch_out, exp_b); end
  endtask

  task automatic test_hold_release;
    snap = exp_b;
    in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      set_vec(1000 + 7*c);
      tick;
      vec_cnt++; if (batch_out !== snap) begin err_cnt++; $display("FAIL hold_batch c=%0d got %0h exp %0h", c, batch_out, snap); end
      vec_cnt++; if (fill_level !== 3'd4 || batch_valid !== 1'b1) begin err_cnt++; $display("FAIL hold_state c=%0d got fill %0d bv %0b exp 4 1", c, fill_level, batch_valid); end
    end
    in_valid = 0;
    batch_ready = 1;
    tick;
    batch_ready = 0;
    #1;
    vec_cnt++; if (batch_valid !== 1'b0) begin err_cnt++; $display("FAIL release_bv got %0b exp 0", batch_valid); end
    vec_cnt++; if (fill_level !== 3'd0) begin err_cnt++; $display("FAIL release_fill got %0d exp 0", fill_level); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL release_in_ready got %0b exp 1", in_ready); end
    vec_cnt++; if (batch_out !== snap) begin err_cnt++; $display("FAIL release_slots_kept got %0h exp %0h", batch_out, snap); end
  endtask

  task automatic test_gapped;
    logic [6:0] pat;
    int a;
    pat = 7'b1011001;
    a = 0;
    for (int j = 0; j < 7; j++) begin
      in_valid = pat[j];
      set_vec(100 + 2*j);
      if (pat[j]) begin
        exp_b[a][0] = unit_t'(100 + 2*j);
        exp_b[a][1] = unit_t'(101 + 2*j);
        a++;
      end
      tick;
      if (j == 5) begin
        vec_cnt++; if (batch_valid !== 1'b0 || fill_level !== 3'd3) begin err_cnt++; $display("FAIL gap_mid got bv %0b fill %0d exp 0 3", batch_valid, fill_level); end
      end
    end
    in_valid = 0;
    vec_cnt++; if (batch_valid !== 1'b1 || fill_level !== 3'd4) begin err_cnt++; $display("FAIL gap_full got bv %0b fill %0d exp 1 4", batch_valid, fill_level); end
    vec_cnt++; if (batch_out !== exp_b) begin err_cnt++; $display("FAIL gap_batch got %0h exp %0h", batch_out, exp_b); end
    batch_ready = 1;
    tick;
    batch_ready = 0;
  endtask

  task automatic test_clear_fill;
    in_valid = 1;
    set_vec(200); tick;
    set_vec(202); tick;
    vec_cnt++; if (fill_level !== 3'd2) begin err_cnt++; $display("FAIL clr_pre_fill got %0d exp 2", fill_level); end
    clear = 1;
    set_vec(204);
    #1;
    vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL clr_in_ready got %0b exp 0", in_ready); end
    tick;
    clear = 0;
    #1;
    vec_cnt++; if (fill_level !== 3'd0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL clr_fill got fill %0d rdy %0b exp 0 1", fill_level, in_ready); end
    vec_cnt++; if (batch_out[1][0] !== 16'd202) begin err_cnt++; $display("FAIL clr_slots_untouched got %0d exp 202", batch_out[1][0]); end
    for (int k = 0; k < N; k++) begin
      set_vec(300 + 2*k);
      exp_b[k][0] = unit_t'(300 + 2*k);
      exp_b[k][1] = unit_t'(301 + 2*k);
      tick;
    end
    in_valid = 0;
    vec_cnt++; if (batch_valid !== 1'b1 || batch_out !== exp_b) begin err_cnt++; $display("FAIL clr_refill got bv %0b batch %0h exp 1 %0h", batch_valid, batch_out, exp_b); end
  endtask

  task automatic test_clear_full;
    clear = 1;
    batch_ready = 1;
    tick;
    clear = 0;
    batch_ready = 0;
    #1;
    vec_cnt++; if (batch_valid !== 1'b0) begin err_cnt++; $display("FAIL clrfull_bv got %0b exp 0", batch_valid); end
    vec_cnt++; if (fill_level !== 3'd0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL clrfull_state got fill %0d rdy %0b exp 0 1", fill_level, in_ready); end
    vec_cnt++; if (batch_out !== exp_b) begin err_cnt++; $display("FAIL clrfull_slots got %0h exp %0h", batch_out, exp_b); end
  endtask

  task automatic test_async_reset;
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      set_vec(400 + 2*k);
      tick;
    end
    vec_cnt++; if (fill_level !== 3'd3) begin err_cnt++; $display("FAIL arst_pre_fill got %0d exp 3", fill_level); end
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    vec_cnt++; if (batch_valid !== 1'b0 || fill_level !== 3'd0) begin err_cnt++; $display("FAIL arst_state got bv %0b fill %0d exp 0 0", batch_valid, fill_level); end
    vec_cnt++; if (batch_out !== '0) begin err_cnt++; $display("FAIL arst_slots got %0h exp 0", batch_out); end
    tick;
    #2;
    rst_n = 1;
    tick;
    test_stream;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_hold_release;
    test_gapped;
    test_clear_fill;
    test_clear_full;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
